p_wb_ctrl: RTL and testbench
============================

P_WB_CTRL -- requirements
Module: p_wb_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, width of one register word.
REQ-002 SHALL have parameter DEPTH, default 4, writeback queue entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-high reset (asserted = 1).
REQ-005 SHALL have port vec_valid, input, 1, paired vector result offered.
REQ-006 SHALL have port vec_ready, output, 1, vector result accepted this cycle when high with vec_valid.
REQ-007 SHALL have port vec_rd, input, 5, destination base register.
REQ-008 SHALL have ports vec_lo / vec_hi, input, REG_WIDTH each, words for rd and rd+1.
REQ-009 SHALL have port fti_valid, input, 1, scalar single-word result offered.
REQ-010 SHALL have port fti_ready, output, 1, scalar accepted when high with fti_valid.
REQ-011 SHALL have ports fti_rd, input, 5, and fti_data, input, REG_WIDTH.
REQ-012 SHALL have port wb_stall, input, 1, register file write port unavailable this cycle.
REQ-013 SHALL have port flush, input, 1, discard all queued and offered results.
REQ-014 SHALL have ports wr_enable, reg_fti_ctrl, output, 1 each; rd_address, output, 5; dataout_1, dataout_2, output, REG_WIDTH: register file write port.
REQ-015 SHALL have ports wb_err, output, 1, one-cycle pulse on dropped illegal pair; occupancy, output, $clog2(DEPTH)+1.

Function
REQ-016 SHALL enqueue at most one result per cycle; vec_ready/fti_ready only assert when the queue is not full and flush is low.
REQ-017 SHALL arbitrate round-robin when both sources are valid: grant alternates, first grant after reset to vec; the loser sees ready low.
REQ-018 SHALL store per entry: kind (PAIR/SINGLE), rd, word1, word2 (word2 zero for SINGLE).
REQ-019 SHALL dequeue the head entry when wb_stall is low, driving wr_enable=1 for exactly that cycle, reg_fti_ctrl=1 for SINGLE / 0 for PAIR, rd_address=rd, dataout_1=word1, dataout_2=word2.
REQ-020 SHALL hold wr_enable=0 and all data outputs at 0 when nothing is dequeued.
REQ-021 SHALL reject at enqueue any PAIR with vec_rd odd (covers rd=31 wrap): accept handshake, store nothing, pulse wb_err next cycle.
REQ-022 SHALL support enqueue and dequeue in the same cycle, including when full (dequeue frees no slot for that cycle's ready; ready derives from registered occupancy).
REQ-023 SHALL preserve acceptance order on the write port.
REQ-024 SHALL, on flush, empty the queue at the next edge, suppress wr_enable that cycle, and keep arbitration pointer unchanged.
REQ-025 SHALL update occupancy as +1 enqueue, -1 dequeue, 0 both; pointers wrap modulo DEPTH.
REQ-026 Default latency SHALL be one cycle from accept to wr_enable with empty queue and no stall.

Reset
REQ-027 SHALL on rst_n=1 asynchronously clear queue, pointers, occupancy=0, arbitration to vec, wr_enable=0, reg_fti_ctrl=0, rd_address=0, dataout_1/2=0, wb_err=0, readies=0 while reset is asserted.
REQ-028 SHALL discard in-flight entries on reset mid-operation; no write issues in the first cycle after release.

Configuration
REQ-029 Macro P_WB_BYPASS_EN defined: when queue empty and wb_stall low, the granted legal result SHALL be written combinationally in the accept cycle (zero latency) and not enqueued.
REQ-030 Macro P_WB_BYPASS_EN undefined: all results SHALL pass through the queue (REQ-026 latency).

Structure
REQ-031 Shared package p_wb_pkg SHALL hold wb_kind_e (PAIR, SINGLE) and typedef wb_entry_t.
REQ-032 Queue storage and pointers SHALL be a sub-module p_wb_fifo; arbitration, legality check and port drive stay in p_wb_ctrl.

Verification
REQ-033 Single fti_rd=5, data=0xA5 -> next cycle wr_enable=1, reg_fti_ctrl=1, rd_address=5, dataout_1=0xA5, dataout_2=0.
REQ-034 Pair vec_rd=4, lo=0x11, hi=0x22 -> wr_enable=1, reg_fti_ctrl=0, rd_address=4, dataout_1=0x11, dataout_2=0x22.
REQ-035 Both valid every cycle, wb_stall low -> grants vec, fti, vec, fti; writes in same order.
REQ-036 wb_stall high, 6 offers -> 4 accepted, readies low, occupancy=4; release stall -> 4 writes in order.
REQ-037 Pair vec_rd=31 -> vec_ready=1, wb_err pulse, no wr_enable ever.
REQ-038 Queue at 3 entries, assert flush -> occupancy=0 next cycle, no wr_enable; reset mid-stream likewise.

Source files
------------

// File: rtl/p_wb_pkg.sv
// Shared types for the paired/scalar writeback controller.
// Entry words are stored at WB_MAX_W bits; REG_WIDTH must not exceed it.
package p_wb_pkg;

  localparam int WB_MAX_W = 128;

  typedef enum logic {
    PAIR   = 1'b0,
    SINGLE = 1'b1
  } wb_kind_e;

  typedef struct packed {
    wb_kind_e              kind;
    logic [4:0]            rd;
    logic [WB_MAX_W-1:0]   word1;
    logic [WB_MAX_W-1:0]   word2;
  } wb_entry_t;

  function automatic wb_entry_t wb_none();
    wb_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/p_wb_fifo.sv
// Writeback queue: DEPTH entries, power-of-two pointers that wrap.
// Flush clears pointers and occupancy at the next edge.
module p_wb_fifo
  import p_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  wb_entry_t  i_entry,
  output wb_entry_t  o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic [AW:0] o_occ
);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= wb_none();
      end
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_occ == '0);
  assign o_full  = (r_occ == (AW+1)'(DEPTH));
  assign o_occ   = r_occ;

endmodule

// File: rtl/p_wb_ctrl.sv
// Writeback controller: round-robin vec/fti arbitration into a queue.
// Define P_WB_BYPASS_EN for zero-latency writes when the queue is empty.
module p_wb_ctrl
  import p_wb_pkg::*;
#(
  parameter int REG_WIDTH = 64,
  parameter int DEPTH     = 4,
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [4:0]           vec_rd,
  input  logic [REG_WIDTH-1:0] vec_lo,
  input  logic [REG_WIDTH-1:0] vec_hi,
  input  logic                 fti_valid,
  output logic                 fti_ready,
  input  logic [4:0]           fti_rd,
  input  logic [REG_WIDTH-1:0] fti_data,
  input  logic                 wb_stall,
  input  logic                 flush,
  output logic                 wr_enable,
  output logic                 reg_fti_ctrl,
  output logic [4:0]           rd_address,
  output logic [REG_WIDTH-1:0] dataout_1,
  output logic [REG_WIDTH-1:0] dataout_2,
  output logic                 wb_err,
  output logic [OW-1:0]        occupancy
);

  logic      r_prio_vec;
  logic      r_err;
  logic      w_empty;
  logic      w_full;
  logic      w_can_acc;
  logic      w_vec_acc;
  logic      w_fti_acc;
  logic      w_illegal;
  logic      w_cand;
  logic      w_byp;
  logic      w_push;
  logic      w_deq;
  wb_entry_t w_new;
  wb_entry_t w_head;
  wb_entry_t w_sel;

  // rst_n is active-high despite its name
  assign w_can_acc = ~rst_n & ~flush & ~w_full;
  assign vec_ready = w_can_acc & (~fti_valid | r_prio_vec);
  assign fti_ready = w_can_acc & (~vec_valid | ~r_prio_vec);
  assign w_vec_acc = vec_valid & vec_ready;
  assign w_fti_acc = fti_valid & fti_ready;
  assign w_illegal = w_vec_acc & vec_rd[0];
  assign w_cand    = (w_vec_acc & ~vec_rd[0]) | w_fti_acc;

  always_comb begin
    w_new = wb_none();
    if (w_fti_acc) begin
      w_new.kind  = SINGLE;
      w_new.rd    = fti_rd;
      w_new.word1 = WB_MAX_W'(fti_data);
    end else begin
      w_new.kind  = PAIR;
      w_new.rd    = vec_rd;
      w_new.word1 = WB_MAX_W'(vec_lo);
      w_new.word2 = WB_MAX_W'(vec_hi);
    end
  end

`ifdef P_WB_BYPASS_EN
  assign w_byp = w_empty & ~wb_stall & w_cand;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_cand & ~w_byp;
  assign w_deq  = ~w_empty & ~wb_stall & ~flush;

  p_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .i_push  (w_push),
    .i_pop   (w_deq),
    .i_flush (flush),
    .i_entry (w_new),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_occ   (occupancy)
  );

  always_comb begin
    w_sel = wb_none();
    unique case (1'b1)
      w_deq:   w_sel = w_head;
      w_byp:   w_sel = w_new;
      default: w_sel = wb_none();
    endcase
  end

  assign wr_enable    = w_deq | w_byp;
  assign reg_fti_ctrl = (w_sel.kind == SINGLE);
  assign rd_address   = w_sel.rd;
  assign dataout_1    = REG_WIDTH'(w_sel.word1);
  assign dataout_2    = REG_WIDTH'(w_sel.word2);
  assign wb_err       = r_err;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_prio_vec <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_vec_acc) begin
        r_prio_vec <= 1'b0;
      end else if (w_fti_acc) begin
        r_prio_vec <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p_wb_ctrl.sv
// Directed bench for p_wb_ctrl in its default (queued) build.
module tb_p_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_valid;
  logic        vec_ready;
  logic [4:0]  vec_rd;
  logic [63:0] vec_lo;
  logic [63:0] vec_hi;
  logic        fti_valid;
  logic        fti_ready;
  logic [4:0]  fti_rd;
  logic [63:0] fti_data;
  logic        wb_stall;
  logic        flush;
  logic        wr_enable;
  logic        reg_fti_ctrl;
  logic [4:0]  rd_address;
  logic [63:0] dataout_1;
  logic [63:0] dataout_2;
  logic        wb_err;
  logic [2:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  p_wb_ctrl #(
    .REG_WIDTH (64),
    .DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_rd       (vec_rd),
    .vec_lo       (vec_lo),
    .vec_hi       (vec_hi),
    .fti_valid    (fti_valid),
    .fti_ready    (fti_ready),
    .fti_rd       (fti_rd),
    .fti_data     (fti_data),
    .wb_stall     (wb_stall),
    .flush        (flush),
    .wr_enable    (wr_enable),
    .reg_fti_ctrl (reg_fti_ctrl),
    .rd_address   (rd_address),
    .dataout_1    (dataout_1),
    .dataout_2    (dataout_2),
    .wb_err       (wb_err),
    .occupancy    (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic fti,
                        input logic [4:0] rd, input logic [63:0] d1,
                        input logic [63:0] d2);
    chk({tag, ".wr_enable"}, 64'(wr_enable), 64'd1);
    chk({tag, ".fti_ctrl"}, 64'(reg_fti_ctrl), 64'(fti));
    chk({tag, ".rd"}, 64'(rd_address), 64'(rd));
    chk({tag, ".d1"}, dataout_1, d1);
    chk({tag, ".d2"}, dataout_2, d2);
  endtask

  initial begin
    rst_n = 1'b1;
    vec_valid = 1'b0; vec_rd = '0; vec_lo = '0; vec_hi = '0;
    fti_valid = 1'b0; fti_rd = '0; fti_data = '0;
    wb_stall = 1'b0; flush = 1'b0;

    // reset state
    cyc();
    vec_valid = 1'b1; fti_valid = 1'b1;
    #1;
    chk("rst.vec_ready", 64'(vec_ready), 64'd0);
    chk("rst.fti_ready", 64'(fti_ready), 64'd0);
    chk("rst.wr_enable", 64'(wr_enable), 64'd0);
    chk("rst.fti_ctrl", 64'(reg_fti_ctrl), 64'd0);
    chk("rst.rd", 64'(rd_address), 64'd0);
    chk("rst.d1", dataout_1, 64'd0);
    chk("rst.d2", dataout_2, 64'd0);
    chk("rst.err", 64'(wb_err), 64'd0);
    chk("rst.occ", 64'(occupancy), 64'd0);
    vec_valid = 1'b0; fti_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();

    // round robin with both sources valid
    vec_valid = 1'b1; vec_rd = 5'd2; vec_lo = 64'h100; vec_hi = 64'h101;
    fti_valid = 1'b1; fti_rd = 5'd7; fti_data = 64'h200;
    #1;
    chk("rr0.vec_ready", 64'(vec_ready), 64'd1);
    chk("rr0.fti_ready", 64'(fti_ready), 64'd0);
    chk("rr0.wr_enable", 64'(wr_enable), 64'd0);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("rr.vec_ready", 64'(vec_ready), 64'(k % 2 == 0));
      chk("rr.fti_ready", 64'(fti_ready), 64'(k % 2 == 1));
      if (k % 2 == 1) chk_wr("rr.vwr", 1'b0, 5'd2, 64'h100, 64'h101);
      else            chk_wr("rr.fwr", 1'b1, 5'd7, 64'h200, 64'h0);
      chk("rr.occ", 64'(occupancy), 64'd1);
    end
    cyc();
    vec_valid = 1'b0; fti_valid = 1'b0;
    #1;
    chk_wr("rr4", 1'b1, 5'd7, 64'h200, 64'h0);
    cyc();
    chk("rr5.wr_enable", 64'(wr_enable), 64'd0);
    chk("rr5.occ", 64'(occupancy), 64'd0);

    // single-word result, one cycle latency
    fti_valid = 1'b1; fti_rd = 5'd5; fti_data = 64'hA5;
    #1;
    chk("s.fti_ready", 64'(fti_ready), 64'd1);
    chk("s.wr_early", 64'(wr_enable), 64'd0);
    cyc();
    fti_valid = 1'b0;
    #1;
    chk_wr("s", 1'b1, 5'd5, 64'hA5, 64'h0);
    chk("s.occ", 64'(occupancy), 64'd1);
    cyc();
    chk("s.wr_after", 64'(wr_enable), 64'd0);
    chk("s.d1_after", dataout_1, 64'd0);

    // paired result
    vec_valid = 1'b1; vec_rd = 5'd4; vec_lo = 64'h11; vec_hi = 64'h22;
    #1;
    chk("p.vec_ready", 64'(vec_ready), 64'd1);
    cyc();
    vec_valid = 1'b0;
    #1;
    chk_wr("p", 1'b0, 5'd4, 64'h11, 64'h22);
    cyc();
    chk("p.wr_after", 64'(wr_enable), 64'd0);

    // stall: six offers, four fit
    wb_stall = 1'b1;
    fti_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fti_rd = 5'(10 + i); fti_data = 64'h30 + 64'(i);
      #1;
      chk("st.fti_ready", 64'(fti_ready), 64'(i < 4));
      chk("st.wr_enable", 64'(wr_enable), 64'd0);
      chk("st.occ", 64'(occupancy), 64'((i < 4) ? i : 4));
      cyc();
    end
    fti_valid = 1'b0;
    #1;
    chk("st.occ_full", 64'(occupancy), 64'd4);
    chk("st.ready_full", 64'(fti_ready), 64'd0);
    wb_stall = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_wr("st.drain", 1'b1, 5'(10 + k), 64'h30 + 64'(k), 64'h0);
      chk("st.drain_occ", 64'(occupancy), 64'(4 - k));
      cyc();
    end
    chk("st.empty_wr", 64'(wr_enable), 64'd0);
    chk("st.empty_occ", 64'(occupancy), 64'd0);

    // odd pair destination is dropped with an error pulse
    vec_valid = 1'b1; vec_rd = 5'd31; vec_lo = 64'h77; vec_hi = 64'h88;
    #1;
    chk("err.vec_ready", 64'(vec_ready), 64'd1);
    cyc();
    vec_valid = 1'b0;
    #1;
    chk("err.pulse", 64'(wb_err), 64'd1);
    chk("err.wr", 64'(wr_enable), 64'd0);
    chk("err.occ", 64'(occupancy), 64'd0);
    cyc();
    chk("err.pulse_end", 64'(wb_err), 64'd0);
    chk("err.wr2", 64'(wr_enable), 64'd0);

    // flush with three queued entries
    wb_stall = 1'b1;
    fti_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fti_rd = 5'(20 + i); fti_data = 64'h50 + 64'(i);
      cyc();
    end
    fti_valid = 1'b0;
    #1;
    chk("fl.occ3", 64'(occupancy), 64'd3);
    flush = 1'b1; wb_stall = 1'b0;
    vec_valid = 1'b1; vec_rd = 5'd8; vec_lo = 64'h61; vec_hi = 64'h62;
    fti_valid = 1'b1;
    #1;
    chk("fl.wr", 64'(wr_enable), 64'd0);
    chk("fl.vec_ready", 64'(vec_ready), 64'd0);
    chk("fl.fti_ready", 64'(fti_ready), 64'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl.occ0", 64'(occupancy), 64'd0);
    chk("fl.wr_next", 64'(wr_enable), 64'd0);
    chk("fl.prio_vec", 64'(vec_ready), 64'd1);
    chk("fl.prio_fti", 64'(fti_ready), 64'd0);
    cyc();
    vec_valid = 1'b0; fti_valid = 1'b0;
    #1;
    chk_wr("fl.after", 1'b0, 5'd8, 64'h61, 64'h62);
    cyc();

    // reset in the middle of a stream
    wb_stall = 1'b1;
    fti_valid = 1'b1; fti_rd = 5'd3; fti_data = 64'h99;
    cyc();
    cyc();
    fti_valid = 1'b0;
    #1;
    chk("mr.occ2", 64'(occupancy), 64'd2);
    rst_n = 1'b1; wb_stall = 1'b0; fti_valid = 1'b1;
    #1;
    chk("mr.occ_async", 64'(occupancy), 64'd0);
    chk("mr.ready", 64'(fti_ready), 64'd0);
    chk("mr.wr", 64'(wr_enable), 64'd0);
    cyc();
    rst_n = 1'b0; fti_valid = 1'b0;
    #1;
    chk("mr.wr_release", 64'(wr_enable), 64'd0);
    chk("mr.occ_release", 64'(occupancy), 64'd0);
    vec_valid = 1'b1; fti_valid = 1'b1;
    #1;
    chk("mr.prio_vec", 64'(vec_ready), 64'd1);
    cyc();
    vec_valid = 1'b0; fti_valid = 1'b0;
    #1;
    chk_wr("mr.first", 1'b0, 5'd8, 64'h61, 64'h62);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
